// File: rtl/crypto_seq_ctrl_pkg.sv
// Shared constants, FSM state type and decode helper for the custom-0
// encryption sequencer.
package crypto_pkg;

  localparam logic [6:0] OP_CUSTOM0 = 7'b0001011;
  localparam logic [2:0] F3_ENC     = 3'b000;
  localparam logic [2:0] F3_DEC     = 3'b001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_e;

  function automatic logic is_legal_f3(input logic [2:0] f3);
    return (f3 == F3_ENC) || (f3 == F3_DEC);
  endfunction

endpackage

// File: rtl/crypto_seq_ctrl_key_rot.sv
// 32-bit round-key register: parallel load, or rotate by one bit
// (left for encrypt, right for decrypt).
module crypto_key_rot (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  input  logic        rot_i,
  input  logic        rot_right_i,
  output logic [31:0] key_o
);

  logic [31:0] key_q;
  logic [31:0] key_d;

  always_comb begin
    key_d = key_q;
    if (load_i) begin
      key_d = load_val_i;
    end else if (rot_i) begin
      key_d = rot_right_i ? {key_q[0], key_q[31:1]} : {key_q[30:0], key_q[31]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= 32'h0;
    end else begin
      key_q <= key_d;
    end
  end

  assign key_o = key_q;

endmodule

// File: rtl/crypto_seq_ctrl.sv
// Multi-cycle sequencer for the custom-0 encrypt/decrypt instruction.
// Optional completed-op counter is built when CRYPTO_SEQ_PERF_CNT_EN is defined.
module crypto_seq_ctrl
  import crypto_pkg::*;
#(
  parameter int ROUNDS  = 10,
  parameter int ROUND_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               dec_valid_i,
  input  logic [6:0]         dec_op_i,
  input  logic [2:0]         dec_funct3_i,
  input  logic [4:0]         dec_rd_i,
  input  logic [31:0]        rs1_data_i,
  input  logic [31:0]        rs2_data_i,
  input  logic               flush_i,
  output logic [31:0]        rnd_data_o,
  output logic [31:0]        rnd_key_o,
  output logic [ROUND_W-1:0] rnd_idx_o,
  output logic               rnd_dec_o,
  input  logic [31:0]        rnd_data_i,
  input  logic               pipe_wen_i,
  input  logic [4:0]         pipe_wsel_i,
  input  logic [31:0]        pipe_wdata_i,
  output logic               gpr_wen_o,
  output logic [4:0]         gpr_wsel_o,
  output logic [31:0]        gpr_wdata_o,
  output logic               stall_o,
  output logic               busy_o,
  output logic               illegal_o,
  output logic [31:0]        perf_ops_o
);

  localparam logic [ROUND_W-1:0] LAST_IDX = ROUND_W'(ROUNDS - 1);

  state_e             state_q, state_d;
  logic [31:0]        data_q, data_d;
  logic [ROUND_W-1:0] cnt_q, cnt_d;
  logic [ROUND_W-1:0] idx_q, idx_d;
  logic [4:0]         rd_q, rd_d;
  logic               mode_q, mode_d;

  logic op_hit;
  logic accept;
  logic write_now;
  logic op_done;

  assign op_hit    = dec_valid_i && (dec_op_i == OP_CUSTOM0);
  assign accept    = (state_q == IDLE) && op_hit && is_legal_f3(dec_funct3_i) && !flush_i;
  assign illegal_o = (state_q == IDLE) && op_hit && !is_legal_f3(dec_funct3_i) && !flush_i;

  // A pipeline writeback owns the port; the result waits in WB until it is free.
  assign write_now = (state_q == WB) && (rd_q != 5'd0) && !pipe_wen_i && !flush_i;
  assign op_done   = (state_q == WB) && !flush_i && ((rd_q == 5'd0) || !pipe_wen_i);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rd_d    = rd_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = rs1_data_i;
          rd_d    = dec_rd_i;
          mode_d  = dec_funct3_i[0];
          idx_d   = dec_funct3_i[0] ? LAST_IDX : '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          data_d = rnd_data_i;
          idx_d  = mode_q ? idx_q - 1'b1 : idx_q + 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d = WB;
          end
        end
      end
      WB: begin
        if (flush_i || op_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= 32'h0;
      cnt_q   <= '0;
      idx_q   <= '0;
      rd_q    <= 5'd0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rd_q    <= rd_d;
      mode_q  <= mode_d;
    end
  end

  crypto_key_rot u_key_rot (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (accept),
    .load_val_i  (rs2_data_i),
    .rot_i       (state_q == RUN),
    .rot_right_i (mode_q),
    .key_o       (rnd_key_o)
  );

  assign rnd_data_o = data_q;
  assign rnd_idx_o  = idx_q;
  assign rnd_dec_o  = mode_q;

  assign gpr_wen_o   = write_now ? 1'b1   : pipe_wen_i;
  assign gpr_wsel_o  = write_now ? rd_q   : pipe_wsel_i;
  assign gpr_wdata_o = write_now ? data_q : pipe_wdata_i;

  assign stall_o = accept || (state_q == RUN) || ((state_q == WB) && !write_now);
  assign busy_o  = (state_q != IDLE);

`ifdef CRYPTO_SEQ_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (op_done) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= 32'h0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_ops_o = perf_q;
`else
  assign perf_ops_o = 32'h0;
`endif

endmodule

// File: tb/tb_crypto_seq_ctrl.sv
// Randomized scoreboard bench for crypto_seq_ctrl with an XOR round unit
// and a loop-based reference model of the key schedule and result.
module tb_crypto_seq_ctrl;
  import crypto_pkg::*;

  localparam int ROUNDS  = 10;
  localparam int ROUND_W = 4;
  localparam int EW      = 32 + 5 + 32;

  logic               clk;
  logic               rst_n;
  logic               dec_valid_i;
  logic [6:0]         dec_op_i;
  logic [2:0]         dec_funct3_i;
  logic [4:0]         dec_rd_i;
  logic [31:0]        rs1_data_i;
  logic [31:0]        rs2_data_i;
  logic               flush_i;
  logic [31:0]        rnd_data_o;
  logic [31:0]        rnd_key_o;
  logic [ROUND_W-1:0] rnd_idx_o;
  logic               rnd_dec_o;
  logic [31:0]        rnd_data_i;
  logic               pipe_wen_i;
  logic [4:0]         pipe_wsel_i;
  logic [31:0]        pipe_wdata_i;
  logic               gpr_wen_o;
  logic [4:0]         gpr_wsel_o;
  logic [31:0]        gpr_wdata_o;
  logic               stall_o;
  logic               busy_o;
  logic               illegal_o;
  logic [31:0]        perf_ops_o;

  crypto_seq_ctrl #(.ROUNDS(ROUNDS), .ROUND_W(ROUND_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dec_valid_i  (dec_valid_i),
    .dec_op_i     (dec_op_i),
    .dec_funct3_i (dec_funct3_i),
    .dec_rd_i     (dec_rd_i),
    .rs1_data_i   (rs1_data_i),
    .rs2_data_i   (rs2_data_i),
    .flush_i      (flush_i),
    .rnd_data_o   (rnd_data_o),
    .rnd_key_o    (rnd_key_o),
    .rnd_idx_o    (rnd_idx_o),
    .rnd_dec_o    (rnd_dec_o),
    .rnd_data_i   (rnd_data_i),
    .pipe_wen_i   (pipe_wen_i),
    .pipe_wsel_i  (pipe_wsel_i),
    .pipe_wdata_i (pipe_wdata_i),
    .gpr_wen_o    (gpr_wen_o),
    .gpr_wsel_o   (gpr_wsel_o),
    .gpr_wdata_o  (gpr_wdata_o),
    .stall_o      (stall_o),
    .busy_o       (busy_o),
    .illegal_o    (illegal_o),
    .perf_ops_o   (perf_ops_o)
  );

  // Combinational round unit used by the bench.
  assign rnd_data_i = rnd_data_o ^ rnd_key_o;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int          checks   = 0;
  int          failures = 0;
  logic [EW-1:0] exp_q[$];
  logic [31:0] exp_perf = 32'h0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] perf_expect();
`ifdef CRYPTO_SEQ_PERF_CNT_EN
    return exp_perf;
`else
    return 32'h0;
`endif
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [31:0] rot(input logic [31:0] x, input logic right, input int n);
    logic [31:0] v;
    v = x;
    for (int i = 0; i < n; i++) begin
      v = right ? {v[0], v[31:1]} : {v[30:0], v[31]};
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_key(input logic enc, input logic [31:0] k, input int r);
    return rot(k, !enc, r);
  endfunction

  function automatic logic [31:0] ref_result(input logic enc, input logic [31:0] d, input logic [31:0] k);
    logic [31:0] v;
    v = d;
    for (int r = 0; r < ROUNDS; r++) v = v ^ ref_key(enc, k, r);
    return v;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && (gpr_wen_o || pipe_wen_i)) begin
      if (pipe_wen_i) begin
        check32("pipe_pass_wen", {31'h0, gpr_wen_o}, 32'h1);
        check32("pipe_pass_wsel", {27'h0, gpr_wsel_o}, {27'h0, pipe_wsel_i});
        check32("pipe_pass_wdata", gpr_wdata_o, pipe_wdata_i);
      end else if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got wsel=%0d wdata=%h expected no write (cycle %0d)",
                 gpr_wsel_o, gpr_wdata_o, cyc);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check32("wb_cycle", 32'(cyc), e[68:37]);
        check32("wb_wsel", {27'h0, gpr_wsel_o}, {27'h0, e[36:32]});
        check32("wb_wdata", gpr_wdata_o, e[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // abort_kind: 0 none, 1 flush in RUN cycle abort_at, 2 reset in RUN cycle abort_at
  task automatic do_op(input logic enc, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [4:0] rd, input int n_pipe, input int abort_at,
                       input int abort_kind);
    int t0;
    @(posedge clk); #1;
    dec_valid_i  = 1'b1;
    dec_op_i     = OP_CUSTOM0;
    dec_funct3_i = enc ? F3_ENC : F3_DEC;
    dec_rd_i     = rd;
    rs1_data_i   = rs1;
    rs2_data_i   = rs2;
    t0 = cyc;
    #1;
    check32("accept_stall", {31'h0, stall_o}, 32'h1);
    check32("accept_busy", {31'h0, busy_o}, 32'h0);
    @(posedge clk); #1;
    dec_valid_i = 1'b0;
    rs1_data_i  = $urandom;
    rs2_data_i  = $urandom;
    for (int r = 0; r < ROUNDS; r++) begin
      check32("run_idx", 32'(rnd_idx_o), enc ? 32'(r) : 32'(ROUNDS - 1 - r));
      check32("run_key", rnd_key_o, ref_key(enc, rs2, r));
      check32("run_dec", {31'h0, rnd_dec_o}, {31'h0, !enc});
      check32("run_stall", {31'h0, stall_o}, 32'h1);
      if (abort_kind == 1 && abort_at == r) begin
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        check32("flush_busy", {31'h0, busy_o}, 32'h0);
        check32("flush_stall", {31'h0, stall_o}, 32'h0);
        check32("flush_perf", perf_ops_o, perf_expect());
        return;
      end
      if (abort_kind == 2 && abort_at == r) begin
        rst_n = 1'b0;
        #1;
        exp_perf = 32'h0;
        check32("rst_busy", {31'h0, busy_o}, 32'h0);
        check32("rst_stall", {31'h0, stall_o}, 32'h0);
        check32("rst_data", rnd_data_o, 32'h0);
        check32("rst_key", rnd_key_o, 32'h0);
        check32("rst_idx", 32'(rnd_idx_o), 32'h0);
        check32("rst_dec", {31'h0, rnd_dec_o}, 32'h0);
        check32("rst_gpr_wen", {31'h0, gpr_wen_o}, 32'h0);
        check32("rst_perf", perf_ops_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    if (rd != 5'd0) exp_q.push_back({32'(t0 + ROUNDS + 1 + n_pipe), rd, ref_result(enc, rs1, rs2)});
    check32("wb_busy", {31'h0, busy_o}, 32'h1);
    for (int i = 0; i < n_pipe; i++) begin
      pipe_wen_i   = 1'b1;
      pipe_wsel_i  = 5'($urandom);
      pipe_wdata_i = $urandom;
      #1;
      check32("wb_pipe_stall", {31'h0, stall_o}, 32'h1);
      @(posedge clk); #1;
    end
    pipe_wen_i = 1'b0;
    #1;
    check32("wb_stall", {31'h0, stall_o}, (rd != 5'd0) ? 32'h0 : 32'h1);
    @(posedge clk); #1;
    exp_perf = exp_perf + 32'd1;
    check32("done_busy", {31'h0, busy_o}, 32'h0);
    check32("done_perf", perf_ops_o, perf_expect());
  endtask

  task automatic do_illegal(input logic [2:0] f3);
    @(posedge clk); #1;
    dec_valid_i  = 1'b1;
    dec_op_i     = OP_CUSTOM0;
    dec_funct3_i = f3;
    dec_rd_i     = 5'($urandom);
    #1;
    check32("illegal_pulse", {31'h0, illegal_o}, 32'h1);
    check32("illegal_stall", {31'h0, stall_o}, 32'h0);
    @(posedge clk); #1;
    dec_valid_i = 1'b0;
    #1;
    check32("illegal_clear", {31'h0, illegal_o}, 32'h0);
    check32("illegal_busy", {31'h0, busy_o}, 32'h0);
  endtask

  task automatic do_flush_accept();
    @(posedge clk); #1;
    dec_valid_i  = 1'b1;
    dec_op_i     = OP_CUSTOM0;
    dec_funct3_i = F3_ENC;
    dec_rd_i     = 5'd9;
    flush_i      = 1'b1;
    #1;
    check32("flacc_stall", {31'h0, stall_o}, 32'h0);
    @(posedge clk); #1;
    dec_valid_i = 1'b0;
    flush_i     = 1'b0;
    check32("flacc_busy", {31'h0, busy_o}, 32'h0);
  endtask

  task automatic idle_pipe(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      pipe_wen_i   = 1'($urandom_range(0, 1));
      pipe_wsel_i  = 5'($urandom);
      pipe_wdata_i = $urandom;
    end
    @(posedge clk); #1;
    pipe_wen_i = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n        = 1'b0;
    dec_valid_i  = 1'b0;
    dec_op_i     = 7'h0;
    dec_funct3_i = 3'h0;
    dec_rd_i     = 5'h0;
    rs1_data_i   = 32'h0;
    rs2_data_i   = 32'h0;
    flush_i      = 1'b0;
    pipe_wen_i   = 1'b1;
    pipe_wsel_i  = 5'd3;
    pipe_wdata_i = 32'hA5A5_5A5A;
    repeat (3) @(posedge clk);
    #1;
    check32("reset_busy", {31'h0, busy_o}, 32'h0);
    check32("reset_stall", {31'h0, stall_o}, 32'h0);
    check32("reset_data", rnd_data_o, 32'h0);
    check32("reset_key", rnd_key_o, 32'h0);
    check32("reset_idx", 32'(rnd_idx_o), 32'h0);
    check32("reset_illegal", {31'h0, illegal_o}, 32'h0);
    check32("reset_perf", perf_ops_o, 32'h0);
    check32("reset_gpr_wen", {31'h0, gpr_wen_o}, 32'h1);
    check32("reset_gpr_wsel", {27'h0, gpr_wsel_o}, 32'd3);
    check32("reset_gpr_wdata", gpr_wdata_o, 32'hA5A5_5A5A);
    pipe_wen_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    do_op(1'b1, 32'h0000_0000, 32'h0000_0001, 5'd5, 0, -1, 0);
    do_op(1'b0, 32'h0000_03FF, 32'h0000_0200, 5'd6, 0, -1, 0);
    do_op(1'b1, $urandom, $urandom, 5'd7, 3, -1, 0);
    do_op(1'b1, $urandom, $urandom, 5'd8, 0, 4, 1);
    do_illegal(3'b010);
    do_op(1'b1, $urandom, $urandom, 5'd0, 0, -1, 0);
    do_flush_accept();
    do_op(1'b0, $urandom, $urandom, 5'd11, 0, 2, 2);
    do_op(1'b1, 32'h0000_0000, 32'h0000_0001, 5'd5, 0, -1, 0);

    for (int n = 0; n < 24; n++) begin
      logic [4:0] rd;
      int         kind;
      int         at;
      rd   = 5'($urandom_range(0, 31));
      kind = ($urandom_range(0, 7) == 0) ? 1 : 0;
      at   = $urandom_range(0, ROUNDS - 1);
      do_op(1'($urandom_range(0, 1)), $urandom, $urandom, rd,
            (rd == 5'd0) ? 0 : $urandom_range(0, 3), at, kind);
      case ($urandom_range(0, 3))
        0: do_illegal(3'($urandom_range(2, 7)));
        1: idle_pipe($urandom_range(1, 3));
        default: ;
      endcase
    end

    repeat (3) @(posedge clk);
    #1;
    check32("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/crypto_seq_ctrl.md
Name: crypto_seq_ctrl

Overview:
Multi-cycle sequencer for the custom-0 encryption instruction (opcode 7'b0001011). The decoder suppresses GPR write/enable for this opcode; this block takes over from there.
- Accepts the instruction from decode and stalls the pipeline.
- Steps an external combinational round unit ROUNDS times with a rotating key.
- Arbitrates the GPR write port to write the result to rd.
- Sits between decode, the round datapath and the register file.

Parameters:
ROUNDS, 10, number of round iterations per instruction (>=2)
ROUND_W, 4, width of the round index; must satisfy 2^ROUND_W >= ROUNDS

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
dec_valid_i  in  1  decode stage holds a valid instruction
dec_op_i  in  7  opcode from decode
dec_funct3_i  in  3  000=encrypt, 001=decrypt, others illegal
dec_rd_i  in  5  destination register
rs1_data_i  in  32  plaintext/ciphertext operand
rs2_data_i  in  32  key operand
flush_i  in  1  pipeline flush; aborts the operation
rnd_data_o  out  32  current state to the round unit
rnd_key_o  out  32  current round key
rnd_idx_o  out  ROUND_W  current round index
rnd_dec_o  out  1  decrypt mode to the round unit
rnd_data_i  in  32  round unit result (combinational from rnd_*_o)
pipe_wen_i  in  1  pipeline writeback request
pipe_wsel_i  in  5  pipeline writeback register
pipe_wdata_i  in  32  pipeline writeback data
gpr_wen_o  out  1  GPR write enable
gpr_wsel_o  out  5  GPR write select
gpr_wdata_o  out  32  GPR write data
stall_o  out  1  freeze fetch/decode
busy_o  out  1  state != IDLE
illegal_o  out  1  one-cycle pulse on illegal funct3
perf_ops_o  out  32  completed-op counter (see Optional Feature)

Behaviour:
- Reset: state=IDLE; data_q, key_q, cnt, rd_q, mode_q = 0. All outputs 0 except the gpr_* passthrough of the pipe_* inputs.
- accept = IDLE & dec_valid_i & dec_op_i==7'b0001011 & funct3 in {000,001} & ~flush_i.
- On accept: capture data_q=rs1, key_q=rs2, rd_q, mode_q=funct3[0]. Set idx = 0 (encrypt) or ROUNDS-1 (decrypt). Go to RUN.
- Illegal funct3 in IDLE with the opcode valid: illegal_o=1 for one cycle, stay in IDLE, no stall.
- RUN, each cycle:
  - data_q <= rnd_data_i.
  - key_q rotates left by 1 (encrypt) or right by 1 (decrypt).
  - idx increments (encrypt) or decrements (decrypt).
  - After ROUNDS RUN cycles, go to WB.
- rnd_data_o=data_q, rnd_key_o=key_q, rnd_idx_o=idx, rnd_dec_o=mode_q.
- WB:
  - If rd_q==0: no write, go to IDLE.
  - Else if pipe_wen_i=1: the pipeline write wins, stay in WB.
  - Else: gpr_wen_o=1, gpr_wsel_o=rd_q, gpr_wdata_o=data_q for exactly one cycle, then IDLE.
- GPR mux: outside the WB-write cycle, gpr_* = pipe_* passthrough.
- stall_o = accept | (state==RUN) | (state==WB & ~write_now). It drops in the WB write cycle.
- busy_o = state != IDLE.
- Latency: accept at T, RUN T+1..T+ROUNDS, earliest write at T+ROUNDS+1.
- flush_i in RUN or WB: go to IDLE next cycle, no write, counter not incremented. flush_i wins over a same-cycle accept.
- A new instruction cannot be accepted in the cycle the WB write occurs; the earliest next accept is the following IDLE cycle.
- Reset mid-operation: immediate return to the reset state, no write.

Optional Feature:
- Macro: CRYPTO_SEQ_PERF_CNT_EN.
- Defined: perf_ops_o is a 32-bit counter. It increments on every completed op (the WB write, or WB exit with rd_q==0). It wraps at 2^32 and resets to 0.
- Undefined: perf_ops_o is tied to 32'h0 and no counter flops are built.

Decomposition:
- Shared package crypto_pkg holds:
  - OP_CUSTOM0=7'b0001011
  - F3_ENC=3'b000, F3_DEC=3'b001
  - state enum {IDLE, RUN, WB}
- One natural sub-module: crypto_key_rot (32-bit key register with left/right rotate-by-1 and load).

Test Plan:
- Bench round model rnd_data_i = rnd_data_o ^ rnd_key_o, ROUNDS=10. Encrypt rs1=0x00000000, rs2=0x00000001, rd=5 -> stall for 11 cycles; gpr_wen_o at T+11 with wsel=5, wdata=0x000003FF; rnd_idx_o sequence 0..9.
- Decrypt rs1=0x000003FF, rs2=0x00000200, rd=6 -> keys 0x200 down to 0x1; rnd_idx_o sequence 9..0; write of 0x00000000 to x6.
- Encrypt with pipe_wen_i held high for 3 cycles after reaching WB -> the pipe writes pass through unchanged; the accelerator write occurs on the 4th WB cycle; stall_o stays high until then.
- flush_i pulsed in the 5th RUN cycle -> busy_o=0 on the next cycle; no gpr_wen_o from the accelerator; perf_ops_o unchanged.
- funct3=3'b010 with the opcode valid -> illegal_o one-cycle pulse; stall_o=0; busy_o=0. rd=0 encrypt -> no write, IDLE after WB, perf_ops_o+1 (macro on).
- rst_n asserted during RUN -> all state and outputs at reset values immediately. A subsequent encrypt completes normally with a correct result.
